// File: rtl/ball_paddle_logic.sv
// ball_paddle_logic
//   Game-state engine for a paddle/ball game. One physics step runs on each
//   FRAME_DONE pulse. A step moves the paddle, moves and bounces the ball,
//   detects a miss and tracks lives. Every output is a register, so the
//   renderer sees stable values for the whole visible frame.
//
// Ports
//   CLK            system/pixel clock
//   RESET_N        asynchronous active-low reset
//   FRAME_DONE     one-cycle physics-step strobe from the renderer
//   BTN_LEFT       asynchronous button, paddle left
//   BTN_RIGHT      asynchronous button, paddle right
//   BTN_SERVE      asynchronous button, launch ball / restart after game over
//   PADDLE_X_PIXEL paddle left edge
//   BALL_X_PIXEL   ball left edge
//   BALL_Y_PIXEL   ball top edge
//   LIVES          remaining lives
//   GAME_OVER      high while the game is over
//   BALL_LOST      one-cycle pulse on a miss
//
// Optional feature
//   BREAKOUT_SPEEDUP_EN: every 8 paddle hits the ball step grows by one
//   pixel, capped at BALL_STEP+2. The step falls back to BALL_STEP on serve.

module ball_paddle_logic #(
  parameter logic [9:0] LEFT_INNER_X    = 10'd16,
  parameter logic [9:0] RIGHT_INNER_X   = 10'd784,
  parameter logic [9:0] CEILING_INNER_Y = 10'd24,
  parameter logic [9:0] PADDLE_Y        = 10'd560,
  parameter logic [9:0] PADDLE_LEN      = 10'd64,
  parameter logic [9:0] BALL_SIZE       = 10'd8,
  parameter logic [9:0] BOTTOM_Y        = 10'd600,
  parameter logic [9:0] PADDLE_STEP     = 10'd4,
  parameter logic [9:0] BALL_STEP       = 10'd2,
  parameter logic [5:0] LOST_FRAMES     = 6'd60,
  parameter logic [1:0] START_LIVES     = 2'd3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       FRAME_DONE,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_SERVE,
  output logic [9:0] PADDLE_X_PIXEL,
  output logic [9:0] BALL_X_PIXEL,
  output logic [9:0] BALL_Y_PIXEL,
  output logic [1:0] LIVES,
  output logic       GAME_OVER,
  output logic       BALL_LOST
);

  // 11-bit copies of the geometry so that no sum below can overflow
  localparam logic [10:0] LEFT_E    = {1'b0, LEFT_INNER_X};
  localparam logic [10:0] RIGHT_E   = {1'b0, RIGHT_INNER_X};
  localparam logic [10:0] CEIL_E    = {1'b0, CEILING_INNER_Y};
  localparam logic [10:0] PADDLE_YE = {1'b0, PADDLE_Y};
  localparam logic [10:0] LEN_E     = {1'b0, PADDLE_LEN};
  localparam logic [10:0] SIZE_E    = {1'b0, BALL_SIZE};
  localparam logic [10:0] BOTTOM_E  = {1'b0, BOTTOM_Y};
  localparam logic [10:0] PSTEP_E   = {1'b0, PADDLE_STEP};
  localparam logic [10:0] BSTEP_E   = {1'b0, BALL_STEP};
  localparam logic [10:0] SERVE_OFS = (LEN_E - SIZE_E) >> 1;
  localparam logic [10:0] CENTRE_E  = (LEFT_E + RIGHT_E - LEN_E) >> 1;
  localparam logic [9:0]  RESET_PX  = 10'(CENTRE_E);
  localparam logic [9:0]  RESET_BX  = 10'(CENTRE_E + SERVE_OFS);
  localparam logic [9:0]  SERVE_Y   = 10'(PADDLE_YE - SIZE_E);
  localparam logic [5:0]  LOST_LAST = LOST_FRAMES - 6'd1;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_LOST  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t      state_r;
  logic [9:0]  paddle_x_r, ball_x_r, ball_y_r;
  logic        dx_r;   // 1 = moving right
  logic        dy_r;   // 1 = moving down
  logic [1:0]  lives_r;
  logic        game_over_r, ball_lost_r;
  logic [5:0]  lost_cnt_r;
  logic        left_meta_r, left_sync_r;
  logic        right_meta_r, right_sync_r;
  logic        serve_meta_r, serve_sync_r, serve_prev_r;

  logic [10:0] step_s;
  logic [10:0] px_e_s, bx_e_s, by_e_s;
  logic [9:0]  paddle_next_s, track_x_s, snap_x_s;
  logic [9:0]  ball_x_next_s, ball_y_next_s;
  logic        dx_next_s, dy_next_s, paddle_hit_s, miss_s, serve_rise_s;
  logic [1:0]  lives_dec_s;

`ifdef BREAKOUT_SPEEDUP_EN
  logic [10:0] step_r;
  logic [2:0]  hit_cnt_r;
  assign step_s = step_r;
`else
  assign step_s = BSTEP_E;
`endif

  assign px_e_s = {1'b0, paddle_x_r};
  assign bx_e_s = {1'b0, ball_x_r};
  assign by_e_s = {1'b0, ball_y_r};
  assign lives_dec_s  = lives_r - 2'd1;
  assign serve_rise_s = serve_sync_r && !serve_prev_r;

  // Paddle move with clamping before the subtraction can wrap
  always_comb begin
    paddle_next_s = paddle_x_r;
    if (left_sync_r && !right_sync_r) begin
      if (px_e_s <= LEFT_E + PSTEP_E) paddle_next_s = LEFT_INNER_X;
      else                            paddle_next_s = 10'(px_e_s - PSTEP_E);
    end else if (right_sync_r && !left_sync_r) begin
      if (px_e_s + PSTEP_E >= RIGHT_E - LEN_E) paddle_next_s = 10'(RIGHT_E - LEN_E);
      else                                     paddle_next_s = 10'(px_e_s + PSTEP_E);
    end else begin
      paddle_next_s = paddle_x_r;
    end
    track_x_s = 10'({1'b0, paddle_next_s} + SERVE_OFS);
    snap_x_s  = 10'(px_e_s + SERVE_OFS);
  end

  // Ball motion and bounces from the pre-step ball and paddle
  always_comb begin
    ball_x_next_s = ball_x_r;
    ball_y_next_s = ball_y_r;
    dx_next_s     = dx_r;
    dy_next_s     = dy_r;
    paddle_hit_s  = 1'b0;
    miss_s        = 1'b0;
    if (dx_r) begin
      if (bx_e_s + step_s + SIZE_E >= RIGHT_E) begin
        ball_x_next_s = 10'(RIGHT_E - SIZE_E);
        dx_next_s     = 1'b0;
      end else begin
        ball_x_next_s = 10'(bx_e_s + step_s);
      end
    end else begin
      // x <= LEFT+step is nx <= LEFT without forming a negative nx
      if (bx_e_s <= LEFT_E + step_s) begin
        ball_x_next_s = LEFT_INNER_X;
        dx_next_s     = 1'b1;
      end else begin
        ball_x_next_s = 10'(bx_e_s - step_s);
      end
    end
    if (!dy_r) begin
      if (by_e_s <= CEIL_E + step_s) begin
        ball_y_next_s = CEILING_INNER_Y;
        dy_next_s     = 1'b1;
      end else begin
        ball_y_next_s = 10'(by_e_s - step_s);
      end
    end else begin
      paddle_hit_s = (by_e_s + SIZE_E <= PADDLE_YE) &&
                     (by_e_s + step_s + SIZE_E >= PADDLE_YE) &&
                     (bx_e_s + SIZE_E > px_e_s) &&
                     (bx_e_s < px_e_s + LEN_E);
      if (paddle_hit_s) begin
        ball_y_next_s = SERVE_Y;
        dy_next_s     = 1'b0;
      end else begin
        ball_y_next_s = 10'(by_e_s + step_s);
        miss_s        = (by_e_s + step_s >= BOTTOM_E);
      end
    end
  end

  // Button synchronisers, game FSM and all registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_SERVE;
      paddle_x_r   <= RESET_PX;
      ball_x_r     <= RESET_BX;
      ball_y_r     <= SERVE_Y;
      dx_r         <= 1'b1;
      dy_r         <= 1'b0;
      lives_r      <= START_LIVES;
      game_over_r  <= 1'b0;
      ball_lost_r  <= 1'b0;
      lost_cnt_r   <= 6'd0;
      left_meta_r  <= 1'b0;
      left_sync_r  <= 1'b0;
      right_meta_r <= 1'b0;
      right_sync_r <= 1'b0;
      serve_meta_r <= 1'b0;
      serve_sync_r <= 1'b0;
      serve_prev_r <= 1'b0;
`ifdef BREAKOUT_SPEEDUP_EN
      step_r       <= BSTEP_E;
      hit_cnt_r    <= 3'd0;
`endif
    end else begin
      left_meta_r  <= BTN_LEFT;
      left_sync_r  <= left_meta_r;
      right_meta_r <= BTN_RIGHT;
      right_sync_r <= right_meta_r;
      serve_meta_r <= BTN_SERVE;
      serve_sync_r <= serve_meta_r;
      ball_lost_r  <= 1'b0;
      if (FRAME_DONE) begin
        serve_prev_r <= serve_sync_r;
        case (state_r)
          ST_SERVE: begin
            paddle_x_r <= paddle_next_s;
            ball_x_r   <= track_x_s;
            ball_y_r   <= SERVE_Y;
            if (serve_sync_r) begin
              state_r <= ST_PLAY;
              dx_r    <= 1'b1;
              dy_r    <= 1'b0;
            end
          end
          ST_PLAY: begin
            paddle_x_r <= paddle_next_s;
            if (miss_s) begin
              // ball freezes where it was; only lives and state move on
              ball_lost_r <= 1'b1;
              lives_r     <= lives_dec_s;
              lost_cnt_r  <= 6'd0;
              if (lives_dec_s == 2'd0) begin
                state_r     <= ST_OVER;
                game_over_r <= 1'b1;
              end else begin
                state_r <= ST_LOST;
              end
            end else begin
              ball_x_r <= ball_x_next_s;
              ball_y_r <= ball_y_next_s;
              dx_r     <= dx_next_s;
              dy_r     <= dy_next_s;
`ifdef BREAKOUT_SPEEDUP_EN
              if (paddle_hit_s) begin
                hit_cnt_r <= hit_cnt_r + 3'd1;
                if ((hit_cnt_r == 3'd7) && (step_r < BSTEP_E + 11'd2)) begin
                  step_r <= step_r + 11'd1;
                end
              end
`endif
            end
          end
          ST_LOST: begin
            if (lost_cnt_r == LOST_LAST) begin
              state_r    <= ST_SERVE;
              lost_cnt_r <= 6'd0;
              ball_x_r   <= snap_x_s;
              ball_y_r   <= SERVE_Y;
`ifdef BREAKOUT_SPEEDUP_EN
              step_r     <= BSTEP_E;
`endif
            end else begin
              lost_cnt_r <= lost_cnt_r + 6'd1;
            end
          end
          ST_OVER: begin
            if (serve_rise_s) begin
              state_r     <= ST_SERVE;
              lives_r     <= START_LIVES;
              game_over_r <= 1'b0;
`ifdef BREAKOUT_SPEEDUP_EN
              step_r      <= BSTEP_E;
`endif
            end
          end
          default: begin
            state_r <= ST_SERVE;
          end
        endcase
      end
    end
  end

  assign PADDLE_X_PIXEL = paddle_x_r;
  assign BALL_X_PIXEL   = ball_x_r;
  assign BALL_Y_PIXEL   = ball_y_r;
  assign LIVES          = lives_r;
  assign GAME_OVER      = game_over_r;
  assign BALL_LOST      = ball_lost_r;

endmodule
